// File: rtl/data_mem_responder.sv
// Word-addressed data memory slave for the MEM stage: accepts one load/store,
// inserts WAIT_CYCLES wait states, then holds the response until it is taken.
module data_mem_responder #(
  parameter int DEPTH_WORDS = 64,
  parameter int WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  input  logic        req_write,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        req_ready,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic        busy
);

  localparam int IW = $clog2(DEPTH_WORDS);
  localparam int WAIT_LOAD_I = (WAIT_CYCLES > 0) ? WAIT_CYCLES - 1 : 0;
  localparam logic [3:0] WAIT_LOAD = 4'(WAIT_LOAD_I);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [31:0] rdata_q, rdata_d;
  logic        err_q, err_d;

  logic        write_q;
  logic [31:0] addr_q, wdata_q;

  logic [31:0] mem [DEPTH_WORDS];

  logic        accept;
  logic        enter_resp;
  logic        acc_write;
  logic [31:0] acc_addr;
  logic [31:0] acc_wdata;
  logic        acc_err;
  logic [IW-1:0] acc_idx;
  logic        mem_we;

  assign accept = req_valid && (state_q == S_IDLE);

  // With zero wait states the access happens on the acceptance edge itself,
  // so the live request is used instead of the (not yet loaded) captured copy.
  assign acc_write = (state_q == S_IDLE) ? req_write : write_q;
  assign acc_addr  = (state_q == S_IDLE) ? req_addr  : addr_q;
  assign acc_wdata = (state_q == S_IDLE) ? req_wdata : wdata_q;
  assign acc_idx   = acc_addr[IW+1:2];
  assign acc_err   = (acc_addr[1:0] != 2'b00) || (|acc_addr[31:IW+2]);

  // rst_n gating keeps an edge seen during reset from committing a store.
  assign mem_we = enter_resp && acc_write && !acc_err && rst_n;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    rdata_d    = rdata_q;
    err_d      = err_q;
    enter_resp = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          if (WAIT_CYCLES == 0) begin
            state_d    = S_RESP;
            enter_resp = 1'b1;
          end else begin
            state_d = S_WAIT;
            cnt_d   = WAIT_LOAD;
          end
        end
      end
      S_WAIT: begin
        if (cnt_q == 4'd0) begin
          state_d    = S_RESP;
          enter_resp = 1'b1;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      S_RESP: begin
        if (resp_ready) begin
          state_d = S_IDLE;
          rdata_d = 32'd0;
          err_d   = 1'b0;
        end
      end
      default: state_d = S_IDLE;
    endcase
    if (enter_resp) begin
      err_d   = acc_err;
      rdata_d = (!acc_err && !acc_write) ? mem[acc_idx] : 32'd0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= 4'd0;
      rdata_q <= 32'd0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  // Request capture and storage are data only; reset leaves them untouched.
  always_ff @(posedge clk) begin
    if (accept) begin
      write_q <= req_write;
      addr_q  <= req_addr;
      wdata_q <= req_wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem[acc_idx] <= acc_wdata;
    end
  end

  assign req_ready  = (state_q == S_IDLE);
  assign busy       = (state_q != S_IDLE);
  assign resp_valid = (state_q == S_RESP);
  assign resp_rdata = rdata_q;
  assign resp_err   = err_q;

endmodule

// File: tb/tb_data_mem_responder.sv
// Randomized bench for data_mem_responder: a word-array reference model predicts
// every response; a second instance covers the zero-wait-state configuration.
module tb_data_mem_responder;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid, req_write, resp_ready;
  logic [31:0] req_addr, req_wdata;
  logic        req_ready, resp_valid, resp_err, busy;
  logic [31:0] resp_rdata;

  logic        z_req_valid, z_req_write, z_resp_ready;
  logic [31:0] z_req_addr, z_req_wdata;
  logic        z_req_ready, z_resp_valid, z_resp_err, z_busy;
  logic [31:0] z_resp_rdata;

  int total = 0;
  int bad   = 0;

  logic [31:0] ref_mem [64];

  always #5 clk = ~clk;

  data_mem_responder #(.DEPTH_WORDS(64), .WAIT_CYCLES(2)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_write(req_write), .req_addr(req_addr), .req_wdata(req_wdata),
    .req_ready(req_ready), .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_rdata(resp_rdata), .resp_err(resp_err), .busy(busy)
  );

  data_mem_responder #(.DEPTH_WORDS(64), .WAIT_CYCLES(0)) dut0 (
    .clk(clk), .rst_n(rst_n),
    .req_valid(z_req_valid), .req_write(z_req_write), .req_addr(z_req_addr), .req_wdata(z_req_wdata),
    .req_ready(z_req_ready), .resp_valid(z_resp_valid), .resp_ready(z_resp_ready),
    .resp_rdata(z_resp_rdata), .resp_err(z_resp_err), .busy(z_busy)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // 64 words of 4 bytes: anything unaligned or at/after byte 256 is an error.
  function automatic logic ref_err(input logic [31:0] a);
    return (a % 4 != 0) || (a >= 32'd256);
  endfunction

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_req_ready"}, {31'd0, req_ready}, 32'd1);
    chk({tag, "_busy"}, {31'd0, busy}, 32'd0);
    chk({tag, "_resp_valid"}, {31'd0, resp_valid}, 32'd0);
    chk({tag, "_resp_err"}, {31'd0, resp_err}, 32'd0);
    chk({tag, "_resp_rdata"}, resp_rdata, 32'd0);
  endtask

  // One full transaction; inputs are scrambled while it is in flight and
  // resp_ready is withheld for 'hold' cycles once the response appears.
  task automatic txn(input logic w, input logic [31:0] a, input logic [31:0] d, input int hold);
    logic        e;
    logic [31:0] exp_d;
    int          lat;
    e     = ref_err(a);
    exp_d = (e || w) ? 32'd0 : ref_mem[a / 4 % 64];
    @(negedge clk);
    chk("req_ready_idle", {31'd0, req_ready}, 32'd1);
    req_valid = 1'b1; req_write = w; req_addr = a; req_wdata = d;
    @(posedge clk); #1;
    req_write = ~w; req_addr = $urandom; req_wdata = $urandom;
    lat = 1;
    while (resp_valid !== 1'b1 && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    chk("latency", lat, 32'd3);
    chk("resp_err", {31'd0, resp_err}, {31'd0, e});
    chk("resp_rdata", resp_rdata, exp_d);
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      chk("hold_valid", {31'd0, resp_valid}, 32'd1);
      chk("hold_rdata", resp_rdata, exp_d);
      chk("hold_err", {31'd0, resp_err}, {31'd0, e});
      chk("hold_req_ready", {31'd0, req_ready}, 32'd0);
      req_addr = $urandom; req_write = $urandom_range(0, 1);
    end
    resp_ready = 1'b1;
    @(posedge clk); #1;
    resp_ready = 1'b0;
    chk("done_valid", {31'd0, resp_valid}, 32'd0);
    chk("done_rdata", resp_rdata, 32'd0);
    chk("done_err", {31'd0, resp_err}, 32'd0);
    chk("done_busy", {31'd0, busy}, 32'd0);
    chk("done_req_ready", {31'd0, req_ready}, 32'd1);
    req_valid = 1'b0;
    if (!e && w) ref_mem[a / 4 % 64] = d;
  endtask

  initial begin
    logic [31:0] a;
    logic        zw [7];
    logic [31:0] za [7];
    logic [31:0] zd [7];
    logic [31:0] zmem [64];
    logic        ze;
    logic [31:0] zexp;

    rst_n = 1'b0;
    req_valid = 1'b0; req_write = 1'b0; req_addr = '0; req_wdata = '0; resp_ready = 1'b0;
    z_req_valid = 1'b0; z_req_write = 1'b0; z_req_addr = '0; z_req_wdata = '0; z_resp_ready = 1'b1;
    #2;
    chk_reset_outputs("por");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 64; i++) txn(1'b1, 32'(i * 4), $urandom, 0);

    txn(1'b1, 32'h10, 32'hDEADBEEF, 0);
    txn(1'b0, 32'h10, 32'h0, 0);
    txn(1'b1, 32'h12, 32'h5555AAAA, 0);
    txn(1'b0, 32'h10, 32'h0, 0);
    txn(1'b0, 32'h100, 32'h0, 0);
    txn(1'b0, 32'hFC, 32'h0, 0);
    txn(1'b0, 32'h10, 32'h0, 5);

    // Reset while a store sits in WAIT must leave the old word in place.
    @(negedge clk);
    req_valid = 1'b1; req_write = 1'b1; req_addr = 32'h20; req_wdata = 32'h12345678;
    @(posedge clk); #1;
    req_valid = 1'b0;
    chk("wait_busy", {31'd0, busy}, 32'd1);
    rst_n = 1'b0;
    #1;
    chk_reset_outputs("rst_wait");
    @(posedge clk); #1;
    chk_reset_outputs("rst_wait_edge");
    @(negedge clk);
    rst_n = 1'b1;
    txn(1'b0, 32'h20, 32'h0, 0);

    // Reset with a response pending discards it.
    @(negedge clk);
    req_valid = 1'b1; req_write = 1'b0; req_addr = 32'h40;
    @(posedge clk); #1;
    req_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("resp_pending", {31'd0, resp_valid}, 32'd1);
    rst_n = 1'b0;
    #1;
    chk_reset_outputs("rst_resp");
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("after_rst_valid", {31'd0, resp_valid}, 32'd0);
    chk("after_rst_ready", {31'd0, req_ready}, 32'd1);

    for (int n = 0; n < 40; n++) begin
      case ($urandom_range(0, 9))
        7:       a = (32'($urandom_range(0, 63)) * 4) + 32'($urandom_range(1, 3));
        8, 9:    a = ($urandom & 32'hFFFF_FFFC) | 32'h0000_0100;
        default: a = 32'($urandom_range(0, 63)) * 4;
      endcase
      txn(1'($urandom_range(0, 1)), a, $urandom, $urandom_range(0, 3));
    end

    // Zero-wait-state instance: back-to-back requests, one accepted every 2 cycles.
    zw[0] = 1'b1; za[0] = 32'h0;   zd[0] = 32'hA5A5_0001;
    zw[1] = 1'b1; za[1] = 32'h4;   zd[1] = 32'h0BAD_F00D;
    zw[2] = 1'b0; za[2] = 32'h0;   zd[2] = 32'h0;
    zw[3] = 1'b0; za[3] = 32'h4;   zd[3] = 32'h0;
    zw[4] = 1'b0; za[4] = 32'h6;   zd[4] = 32'h0;
    zw[5] = 1'b1; za[5] = 32'h400; zd[5] = 32'hFFFF_FFFF;
    zw[6] = 1'b0; za[6] = 32'h4;   zd[6] = 32'h0;
    @(negedge clk);
    z_req_valid = 1'b1; z_req_write = zw[0]; z_req_addr = za[0]; z_req_wdata = zd[0];
    for (int k = 0; k < 7; k++) begin
      ze   = ref_err(za[k]);
      zexp = (ze || zw[k]) ? 32'd0 : zmem[za[k] / 4 % 64];
      @(posedge clk); #1;
      chk("z_resp_valid", {31'd0, z_resp_valid}, 32'd1);
      chk("z_resp_err", {31'd0, z_resp_err}, {31'd0, ze});
      chk("z_resp_rdata", z_resp_rdata, zexp);
      chk("z_req_ready_busy", {31'd0, z_req_ready}, 32'd0);
      if (!ze && zw[k]) zmem[za[k] / 4 % 64] = zd[k];
      if (k < 6) begin
        z_req_write = zw[k+1]; z_req_addr = za[k+1]; z_req_wdata = zd[k+1];
      end else begin
        z_req_valid = 1'b0;
      end
      @(posedge clk); #1;
      chk("z_done_valid", {31'd0, z_resp_valid}, 32'd0);
      chk("z_req_ready_idle", {31'd0, z_req_ready}, 32'd1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
